// File: rtl/axis_pkg.sv
// axis_pkg
// Shared definitions for the AXI-Stream arbiter/mux slice:
//   - RR_MAX      : widest request vector the round-robin selector handles
//   - SKID_*      : state encoding of the 2-entry skid slice
//                   (bit 0 = main entry valid, bit 1 = temp entry valid)
//   - rr_select() : round-robin pick, request vector + pointer -> index
package axis_pkg;

  localparam int RR_MAX = 16;

  localparam logic [1:0] SKID_EMPTY = 2'b00;
  localparam logic [1:0] SKID_ONE   = 2'b01;
  localparam logic [1:0] SKID_TWO   = 2'b11;

  // Returns the lowest requesting index at or above ptr, wrapping past
  // count-1 back to 0. When nothing requests, ptr is returned unchanged.
  function automatic int rr_select(input logic [RR_MAX-1:0] req,
                                   input int ptr,
                                   input int count);
    int   idx;
    logic found;
    rr_select = ptr;
    found     = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < count) begin
        idx = ptr + i;
        if (idx >= count) idx = idx - count;
        if (!found && req[idx]) begin
          rr_select = idx;
          found     = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// axis_skid_slice
// Two-entry (main + temp) register slice for a valid/ready stream. A beat
// accepted on the input appears on the output one cycle later; the temp
// entry absorbs the beat already in flight when the output stalls, so the
// input ready can be a pure register output and throughput stays at one
// beat per cycle while m_ready is high.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_data/s_valid    : input beat and its valid
//   s_ready           : slice can take a beat this cycle
//   m_data/m_valid    : output beat (held stable while stalled)
//   m_ready           : downstream accepts the output beat
module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);
  import axis_pkg::*;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] temp_data;
  logic             in_fire;
  logic             out_fire;

  assign s_ready  = (state != SKID_TWO);
  assign m_valid  = state[0];
  assign m_data   = main_data;
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: if (in_fire) state <= SKID_ONE;
        SKID_ONE: begin
          if (out_fire && !in_fire)      state <= SKID_EMPTY;
          else if (!out_fire && in_fire) state <= SKID_TWO;
        end
        SKID_TWO: if (out_fire) state <= SKID_ONE;
        default:  state <= SKID_EMPTY;
      endcase
    end
  end

  // Data entries carry no reset; validity lives entirely in state.
  always_ff @(posedge clk) begin
    case (state)
      SKID_EMPTY: if (in_fire) main_data <= s_data;
      SKID_ONE: begin
        if (in_fire) begin
          if (out_fire) main_data <= s_data;
          else          temp_data <= s_data;
        end
      end
      SKID_TWO: if (out_fire) main_data <= temp_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/axis_arb_mux.sv
// axis_arb_mux
// Round-robin arbitrated AXI-Stream multiplexer. One input is granted at a
// time (per packet when LAST_ENABLE=1, per beat otherwise); the granted
// stream passes through a 2-entry skid slice onto m_axis, tagged with its
// source index on m_axis_tid.
// Optional feature: define AXIS_ARB_MUX_PRIO_EN to add the s_prio input;
// requesters with their prio bit set then win over the rest, with
// round-robin order kept inside each class.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   s_axis_t*                    : S_COUNT packed input streams
//   m_axis_t*                    : merged output stream, m_axis_tid = source
//   enable                       : permits new grants (held grants finish)
//   grant_valid, grant_index     : registered current grant
//   s_prio (AXIS_ARB_MUX_PRIO_EN): per-input high-priority flags
module axis_arb_mux #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH  = 1,
  parameter int LAST_ENABLE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
`ifdef AXIS_ARB_MUX_PRIO_EN
  input  logic [S_COUNT-1:0]              s_prio,
`endif
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic [$clog2(S_COUNT)-1:0]      m_axis_tid,
  input  logic                            enable,
  output logic                            grant_valid,
  output logic [$clog2(S_COUNT)-1:0]      grant_index
);
  import axis_pkg::*;

  localparam int ID_WIDTH    = $clog2(S_COUNT);
  localparam int SLICE_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1 + ID_WIDTH;

  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [ID_WIDTH-1:0]    grant_next;
  logic [RR_MAX-1:0]      req_vec;
  logic [DATA_WIDTH-1:0]  sel_tdata;
  logic [KEEP_WIDTH-1:0]  sel_tkeep;
  logic [USER_WIDTH-1:0]  sel_tuser;
  logic                   sel_tlast;
  logic                   sel_tvalid;
  logic                   slice_ready;
  logic                   beat_fire;
  logic                   release_grant;
  logic [SLICE_WIDTH-1:0] slice_in;
  logic [SLICE_WIDTH-1:0] slice_out;

  // Request vector seen by the round-robin picker. With priority enabled,
  // the high class alone is offered whenever any of it is requesting.
  always_comb begin
    req_vec = '0;
    req_vec[S_COUNT-1:0] = s_axis_tvalid;
`ifdef AXIS_ARB_MUX_PRIO_EN
    if (|(s_axis_tvalid & s_prio)) begin
      req_vec = '0;
      req_vec[S_COUNT-1:0] = s_axis_tvalid & s_prio;
    end
`endif
  end

  assign grant_next = ID_WIDTH'(rr_select(req_vec, int'(rr_ptr), S_COUNT));

  // Input mux and one-hot ready on the granted lane.
  always_comb begin
    sel_tdata     = '0;
    sel_tkeep     = '0;
    sel_tuser     = '0;
    sel_tlast     = 1'b0;
    sel_tvalid    = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == ID_WIDTH'(i)) begin
        sel_tdata        = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep        = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tuser        = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_tlast        = s_axis_tlast[i];
        sel_tvalid       = s_axis_tvalid[i];
        s_axis_tready[i] = grant_valid && slice_ready;
      end
    end
  end

  assign beat_fire     = grant_valid && slice_ready && sel_tvalid;
  assign release_grant = beat_fire && (sel_tlast || (LAST_ENABLE == 0));

  // Grant register. A release cycle never arbitrates, so the next grant is
  // decided in the following idle cycle using the advanced pointer. A
  // granted lane dropping tvalid simply stalls; only tlast releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid <= 1'b0;
      grant_index <= '0;
      rr_ptr      <= '0;
    end else if (grant_valid) begin
      if (release_grant) begin
        grant_valid <= 1'b0;
        rr_ptr      <= (grant_index == ID_WIDTH'(S_COUNT - 1)) ? '0 : grant_index + 1'b1;
      end
    end else if (enable && |s_axis_tvalid) begin
      grant_valid <= 1'b1;
      grant_index <= grant_next;
    end
  end

  assign slice_in = {sel_tdata, sel_tkeep, sel_tuser, sel_tlast, grant_index};

  axis_skid_slice #(
    .WIDTH(SLICE_WIDTH)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .s_data  (slice_in),
    .s_valid (grant_valid && sel_tvalid),
    .s_ready (slice_ready),
    .m_data  (slice_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tid} = slice_out;

endmodule
